// File: rtl/shifter_pkg.sv
// Shared mode encodings and helpers for the pipelined barrel shifter.
package shifter_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRA = 3'b001;
    localparam logic [2:0] MODE_ROR = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    // Every encoding above ROL is reserved.
    function automatic logic is_reserved(input logic [2:0] mode);
        return (mode > MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter: shifts or rotates by DIST when en_i is set.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic signed [WIDTH-1:0] sdata;

    assign sdata = data_i;

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                MODE_SLL: data_o = data_i << DIST;
                MODE_SRL: data_o = data_i >> DIST;
                MODE_SRA: data_o = sdata >>> DIST;
                MODE_ROR: data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
                MODE_ROL: data_o = (data_i << DIST) | (data_i >> (WIDTH - DIST));
                default:  data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one log2 level per registered stage, valid/ready with full backpressure.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_z,
    output logic               out_err,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LEVELS = SHAMT_W;

    // The last stage needs neither shamt nor mode, so those carry LEVELS-1 entries.
    logic [LEVELS-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0]   data_q  [LEVELS];
    logic [WIDTH-1:0]   data_d  [LEVELS];
    logic [TAG_W-1:0]   tag_q   [LEVELS];
    logic [TAG_W-1:0]   tag_d   [LEVELS];
    logic [SHAMT_W-1:0] shamt_q [LEVELS-1];
    logic [SHAMT_W-1:0] shamt_d [LEVELS-1];
    logic [2:0]         mode_q  [LEVELS-1];
    logic [2:0]         mode_d  [LEVELS-1];
    logic               z_q, z_d;
    logic               err_q, err_d;

    logic [LEVELS-1:0]  st_vld;
    logic [WIDTH-1:0]   st_data  [LEVELS];
    logic [SHAMT_W-1:0] st_shamt [LEVELS];
    logic [2:0]         st_mode  [LEVELS];
    logic [TAG_W-1:0]   st_tag   [LEVELS];
    logic [WIDTH-1:0]   sh_data  [LEVELS];
    logic [LEVELS-1:0]  rdy;

    // A stage can load unless it and every stage after it are full and the sink is stalled.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < LEVELS; k++) begin
            logic full_run;
            full_run = 1'b1;
            for (int j = k; j < LEVELS; j++) begin
                full_run = full_run & vld_q[j];
            end
            rdy[k] = out_ready | ~full_run;
        end
    end

    assign in_ready = rdy[0] & ~flush;

    genvar k;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign st_vld[k]   = in_valid & in_ready;
                assign st_data[k]  = in_data;
                assign st_shamt[k] = in_shamt;
                assign st_mode[k]  = in_mode;
                assign st_tag[k]   = in_tag;
            end else begin : g_next
                assign st_vld[k]   = vld_q[k-1];
                assign st_data[k]  = data_q[k-1];
                assign st_shamt[k] = shamt_q[k-1];
                assign st_mode[k]  = mode_q[k-1];
                assign st_tag[k]   = tag_q[k-1];
            end

            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_shift_stage (
                .data_i (st_data[k]),
                .en_i   (st_shamt[k][k]),
                .mode_i (st_mode[k]),
                .data_o (sh_data[k])
            );
        end
    endgenerate

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        tag_d   = tag_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        z_d     = z_q;
        err_d   = err_q;

        for (int s = 0; s < LEVELS; s++) begin
            if (rdy[s]) begin
                vld_d[s]  = st_vld[s];
                data_d[s] = sh_data[s];
                tag_d[s]  = st_tag[s];
            end
        end
        for (int s = 0; s < LEVELS - 1; s++) begin
            if (rdy[s]) begin
                shamt_d[s] = st_shamt[s];
                mode_d[s]  = st_mode[s];
            end
        end

        // Flags are derived from the final level's result and travel with it.
        if (rdy[LEVELS-1]) begin
            z_d   = (sh_data[LEVELS-1] == '0);
            err_d = is_reserved(st_mode[LEVELS-1]);
        end

        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            z_q   <= 1'b0;
            err_q <= 1'b0;
            for (int s = 0; s < LEVELS; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
            for (int s = 0; s < LEVELS - 1; s++) begin
                shamt_q[s] <= '0;
                mode_q[s]  <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q[LEVELS-1];
    assign out_data  = data_q[LEVELS-1];
    assign out_tag   = tag_q[LEVELS-1];
    assign out_z     = z_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH=16, TAG_W=4): directed vectors, corner sequences, random scoreboard.
module tb_pipe_shifter;
    import shifter_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [2:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_z;
    logic          out_err;
    logic [TW-1:0] out_tag;

    pipe_shifter #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_z(out_z), .out_err(out_err), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [W-1:0]  data;
        logic          z;
        logic          err;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    logic          log_en = 1'b0;
    logic [TW-1:0] log_tag[$];
    int            log_cyc[$];

    // Reference: bit-level meaning of each mode, computed on the whole operand at once.
    function automatic logic [W-1:0] ref_shift(input logic [2:0] m, input int s, input logic [W-1:0] d);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] tmp;
        logic [W-1:0]   r;
        dd = {d, d};
        case (m)
            3'd0: r = d << s;
            3'd3: r = d >> s;
            3'd1: begin
                r = d >> s;
                if (d[W-1]) r = r | ~(16'hFFFF >> s);
            end
            3'd2: begin tmp = dd >> s; r = tmp[W-1:0]; end
            3'd4: begin tmp = dd << s; r = tmp[2*W-1:W]; end
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: handshakes are observed at the negedge preceding the edge that performs them.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (log_en) begin
                    log_tag.push_back(out_tag);
                    log_cyc.push_back(cyc_cnt);
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: actual output tag 0x%0h data 0x%0h, required no output", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_z", out_z, e.z);
                    check("sb_err", out_err, e.err);
                    check("sb_tag", out_tag, e.tag);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                e.data = ref_shift(in_mode, int'(in_shamt), in_data);
                e.z    = (e.data == 0);
                e.err  = (in_mode > 3'd4);
                e.tag  = in_tag;
                exp_q.push_back(e);
            end
        end else begin
            exp_q.delete();
        end
    end

    // Called at posedge+1; returns edges from the accepting edge (counted as 1) to out_valid.
    task automatic send_one(input logic [2:0] m, input logic [SW-1:0] s, input logic [W-1:0] d,
                            input logic [TW-1:0] t, output int lat);
        int guard;
        in_valid = 1'b1; in_mode = m; in_shamt = s; in_data = d; in_tag = t;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_in_time", (guard < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0]    mode;
        logic [SW-1:0] shamt;
        logic [W-1:0]  din;
        logic [W-1:0]  dout;
        logic          z;
        logic          err;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int lat;
        int idx;
        logic acc;
        int accepted;
        int guard;

        vecs[0] = '{MODE_SLL, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b0};
        vecs[1] = '{MODE_SLL, 4'd1,  16'h8000, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{MODE_SRA, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{MODE_SRL, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{MODE_SRA, 4'd14, 16'h4000, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{MODE_ROR, 4'd4,  16'h1234, 16'h4123, 1'b0, 1'b0};
        vecs[6] = '{MODE_ROL, 4'd4,  16'h1234, 16'h2341, 1'b0, 1'b0};
        vecs[7] = '{MODE_ROR, 4'd0,  16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
        vecs[8] = '{3'b111,   4'd5,  16'hBEEF, 16'hBEEF, 1'b0, 1'b1};
        vecs[9] = '{MODE_SRA, 4'd3,  16'h0000, 16'h0000, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].mode, vecs[i].shamt, vecs[i].din, 4'(i), lat);
            check("vec_latency", lat, 4);
            check("vec_data", out_data, vecs[i].dout);
            check("vec_z", out_z, vecs[i].z);
            check("vec_err", out_err, vecs[i].err);
            check("vec_tag", out_tag, i);
        end
        @(posedge clk); #1;

        // Backpressure: eight ROL-by-4 ops into a stalled sink.
        out_ready = 1'b0;
        log_tag.delete(); log_cyc.delete();
        log_en = 1'b1;
        idx = 0;
        in_valid = 1'b1; in_mode = MODE_ROL; in_shamt = 4'd4; in_data = 16'h0101; in_tag = 4'd0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx >= 8 && log_tag.size() >= 8) break;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 6) begin
                check("bp_accepted", idx, 4);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_hold_data", out_data, 16'h1010);
                check("bp_hold_tag", out_tag, 0);
            end
            if (cyc == 9) begin
                check("bp_stable_data", out_data, 16'h1010);
                check("bp_stable_tag", out_tag, 0);
                check("bp_still_full", in_ready, 0);
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    in_data = 16'h0101 * 16'(idx + 1);
                    in_tag = 4'(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (cyc == 9) out_ready = 1'b1;
        end
        log_en = 1'b0;
        check("bp_drain_count", log_tag.size(), 8);
        for (int i = 0; i < log_tag.size(); i++) begin
            check("bp_drain_tag", log_tag[i], i);
            check("bp_drain_spacing", log_cyc[i] - log_cyc[0], i);
        end

        // Flush with three ops in flight and a fourth offered in the flush cycle.
        repeat (3) @(posedge clk);
        #1;
        log_tag.delete(); log_cyc.delete();
        log_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = MODE_SLL; in_shamt = 4'd1; in_data = 16'h0F00 + 16'(i); in_tag = 4'(9 + i);
            @(posedge clk); #1;
        end
        in_tag = 4'd12; in_data = 16'h00AA;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        send_one(MODE_SRL, 4'd8, 16'hAB00, 4'd13, lat);
        check("post_flush_latency", lat, 4);
        check("post_flush_data", out_data, 16'h00AB);
        check("post_flush_tag", out_tag, 13);
        repeat (6) @(posedge clk);
        #1;
        log_en = 1'b0;
        check("flush_log_count", log_tag.size(), 1);
        if (log_tag.size() > 0) check("flush_log_tag", log_tag[0], 13);

        // Mid-stream reset.
        in_valid = 1'b1; in_mode = MODE_ROR; in_shamt = 4'd3; in_data = 16'h1357; in_tag = 4'd5;
        @(posedge clk); #1;
        in_data = 16'h2468; in_tag = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_z", out_z, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_out_tag", out_tag, 0);
        check("mid_rst_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_ghost", out_valid, 0);

        // Random traffic with random stalls and rare flushes.
        accepted = 0;
        guard = 0;
        while (accepted < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_mode   = 3'($urandom_range(0, 7));
            in_shamt  = 4'($urandom_range(0, 15));
            in_data   = 16'($urandom);
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
            guard++;
        end
        check("rand_accepted", (accepted >= 10000), 1);
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rand_drain_empty", exp_q.size(), 0);
        check("rand_drain_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
